// File: rtl/fetch_unit_pkg.sv
// Shared defaults and helpers for the instruction fetch engine.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package fetch_unit_pkg;

    localparam int          XLEN_DEF     = 64;
    localparam int          INST_W_DEF   = 32;
    localparam int          FQ_DEPTH_DEF = 4;
    localparam logic [63:0] RESET_PC_DEF = 64'h0;
    localparam int          INST_BYTES   = 4;

    function automatic logic pc_misaligned(input logic [1:0] pc_lo);
        return pc_lo != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count; flush beats push/pop.
// Latency: a push is visible at the head on the following cycle.
// Backpressure: in_rdy drops when full; out_vld drops when empty.
module fetch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_vld,
    output logic                       in_rdy,
    input  logic [WIDTH-1:0]           in_dat,
    output logic                       out_vld,
    input  logic                       out_rdy,
    output logic [WIDTH-1:0]           out_dat,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int              AW       = $clog2(DEPTH);
    localparam int              CW       = $clog2(DEPTH+1);
    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;

    assign in_rdy  = (count_q != FULL_CNT);
    assign out_vld = (count_q != '0);
    assign out_dat = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign push    = in_vld & in_rdy;
    assign pop     = out_vld & out_rdy;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = in_dat;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues sequential PCs to imem, queues responses with PC, redirects flush.
// Latency: response at t reaches out_* at t+1; a 1-cycle imem gives one instruction per cycle.
// Backpressure: issue stalls once queued + outstanding + to-drop reaches FQ_DEPTH; imem responses never stall.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int               XLEN     = XLEN_DEF,
    parameter int               INST_W   = INST_W_DEF,
    parameter int               FQ_DEPTH = FQ_DEPTH_DEF,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEF)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_resp_valid,
    input  logic [INST_W-1:0] imem_resp_inst,
    input  logic              imem_resp_err,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] out_inst,
    output logic [XLEN-1:0]   out_pc,
    output logic              out_err
);

    localparam int            CW  = $clog2(FQ_DEPTH+1);
    localparam int            SW  = CW + 2;
    localparam logic [SW-1:0] CAP = SW'(FQ_DEPTH);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [XLEN-1:0]   pc;
        logic              err;
    } fq_ent_t;

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
    logic            misal_pend_q, misal_pend_d;

    logic            req_fire, resp_drop, resp_enq, misal_enq, fq_push, fq_in_rdy;
    logic [CW-1:0]   fq_count;
    logic [SW-1:0]   in_flight;
    logic [XLEN-1:0] resp_pc;
    fq_ent_t         fq_in, fq_out;

    assign in_flight      = SW'(fq_count) + SW'(outstanding_q) + SW'(drop_cnt_q);
    assign imem_req_valid = rst_n & (state_q == ST_RUN) & ~redirect_valid
                          & (in_flight < CAP) & fq_in_rdy;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid & imem_req_ready;
    assign resp_drop      = (drop_cnt_q != '0) | redirect_valid;
    assign resp_enq       = imem_resp_valid & ~resp_drop;
    // Live requests are contiguous behind pc_q, so the oldest one's PC is recomputed.
    assign resp_pc        = pc_q - (XLEN'(outstanding_q) * XLEN'(INST_BYTES));
    // The misaligned-target fault entry waits until every stale response has drained.
    assign misal_enq      = misal_pend_q & (drop_cnt_q == '0);
    assign fq_push        = resp_enq | misal_enq;

    always_comb begin
        fq_in.inst = imem_resp_inst;
        fq_in.pc   = resp_pc;
        fq_in.err  = imem_resp_err;
        if (misal_enq) begin
            fq_in.inst = '0;
            fq_in.pc   = pc_q;
            fq_in.err  = 1'b1;
        end
    end

    fetch_fifo #(
        .WIDTH ($bits(fq_ent_t)),
        .DEPTH (FQ_DEPTH)
    ) u_fq (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (redirect_valid),
        .in_vld  (fq_push),
        .in_rdy  (fq_in_rdy),
        .in_dat  (fq_in),
        .out_vld (out_valid),
        .out_rdy (out_ready),
        .out_dat (fq_out),
        .count   (fq_count)
    );

    assign out_inst = fq_out.inst;
    assign out_pc   = fq_out.pc;
    assign out_err  = fq_out.err;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        misal_pend_d  = misal_pend_q;
        if (redirect_valid) begin
            pc_d          = redirect_pc;
            drop_cnt_d    = outstanding_q + drop_cnt_q - CW'(imem_resp_valid);
            outstanding_d = '0;
            misal_pend_d  = pc_misaligned(redirect_pc[1:0]);
            state_d       = misal_pend_d ? ST_HALT : ST_RUN;
        end else begin
            if (req_fire) begin
                pc_d = pc_q + XLEN'(INST_BYTES);
            end
            if (imem_resp_valid && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - 1'b1;
            end
            outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_enq);
            if (misal_enq) begin
                misal_pend_d = 1'b0;
            end
            if (resp_enq && imem_resp_err) begin
                state_d = ST_HALT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
            misal_pend_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
            misal_pend_q  <= misal_pend_d;
        end
    end

endmodule
